freq_div_monitor: RTL and testbench



---
 rtl/freq_div_monitor_pkg.sv | 36 +++
 rtl/freq_div_monitor_if.sv | 38 +++
 rtl/freq_div_monitor_chan_check.sv | 129 ++++++++++++
 rtl/freq_div_monitor.sv | 65 ++++++
 tb/tb_freq_div_monitor.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/freq_div_monitor_pkg.sv
// Shared types and constants for the divided-clock monitor.
// The channel state machine, the counter widths and the nominal divider
// periods all live here, so the top and the channel checker agree on them.
package freq_div_mon_pkg;

  // Width of the per-channel period counter; it saturates at its maximum.
  localparam int CNT_W  = 8;
  // Width of the consecutive-good-period counter (LOCK_N is at most 15).
  localparam int GOOD_W = 4;

  // Nominal divider periods in CLK_in cycles and the default lock depth.
  localparam int P50_DEF    = 2;
  localparam int P10_DEF    = 10;
  localparam int P1_DEF     = 100;
  localparam int LOCK_N_DEF = 4;

  // Largest value the period counter can hold before it saturates.
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Lock state of one divided clock.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEAS   = 2'd1,
    LOCKED = 2'd2
  } chan_state_t;

  // Increment that sticks at CNT_MAX, so a dead input never wraps back
  // into a plausible-looking period.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (value == CNT_MAX) begin
      return value;
    end
    return value + 1'b1;
  endfunction

endpackage

// File: rtl/freq_div_monitor_if.sv
// Bundle of the divided clocks, the error-clear request and the monitor
// results. The master side is whoever drives the divided clocks and
// consumes the status; the slave side is the monitor itself.
// Bit order of every 3-bit vector is {CLK_1, CLK_10, CLK_50}.
interface freq_div_monitor_if;

  logic       CLK_50_i;
  logic       CLK_10_i;
  logic       CLK_1_i;
  logic       err_clr;
  logic [2:0] tick;
  logic [2:0] locked;
  logic [2:0] err;
  logic       all_locked;

  modport master (
    output CLK_50_i,
    output CLK_10_i,
    output CLK_1_i,
    output err_clr,
    input  tick,
    input  locked,
    input  err,
    input  all_locked
  );

  modport slave (
    input  CLK_50_i,
    input  CLK_10_i,
    input  CLK_1_i,
    input  err_clr,
    output tick,
    output locked,
    output err,
    output all_locked
  );

endinterface

// File: rtl/freq_div_monitor_chan_check.sv
// Checker for a single divided clock. The input comes straight from a
// CLK_in flop in the divider, so it is used without a synchronizer.
// It produces a one-cycle tick per rising edge, measures each period in
// CLK_in cycles, and runs an IDLE/MEAS/LOCKED state machine that reports
// lock and a sticky error when a locked channel goes wrong or stops.
// Legal period range: 1 <= P and 2*P <= 255 so the timeout fits the counter.
module freq_chan_check
  import freq_div_mon_pkg::*;
#(
  parameter int P      = P50_DEF,
  parameter int LOCK_N = LOCK_N_DEF
) (
  input  logic CLK_in,
  input  logic RST,
  input  logic clk_div,
  input  logic err_clr,
  output logic tick,
  output logic locked,
  output logic err
);

  localparam logic [CNT_W-1:0]  PERIOD      = CNT_W'(P);
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(2 * P);
  localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_N);

  logic              prev;
  logic              rise;
  logic [CNT_W-1:0]  cnt;
  logic              period_ok;
  logic              timeout;
  logic              fault;
  logic [GOOD_W-1:0] good;
  logic [GOOD_W-1:0] good_inc;
  chan_state_t       state;

  // A rising edge is a high sample following a low one. The value of cnt
  // in the rise cycle is the measured period of the edge just completed.
  assign rise      = clk_div & ~prev;
  assign period_ok = (cnt == PERIOD);
  assign timeout   = ~rise & (cnt == TIMEOUT_CNT);
  assign good_inc  = good + 1'b1;

  // Only a channel that had already locked is reported as broken; a channel
  // that never locked just keeps trying.
  assign fault = (state == LOCKED) & ((rise & ~period_ok) | timeout);

  // Edge detector and tick strobe: tick follows the sampled edge by a cycle.
  always_ff @(posedge CLK_in or posedge RST) begin
    if (RST) begin
      prev <= 1'b0;
      tick <= 1'b0;
    end else begin
      prev <= clk_div;
      tick <= rise;
    end
  end

  // Period counter: restarts at 1 on each edge, otherwise counts up and sticks at max.
  always_ff @(posedge CLK_in or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_W'(1);
    end else begin
      cnt <= sat_inc(cnt);
    end
  end

  // Lock state machine with registered locked flag and sticky err flag.
  always_ff @(posedge CLK_in or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      good   <= '0;
      locked <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (fault) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (rise) begin
            state <= MEAS;
            good  <= '0;
          end
        end

        MEAS: begin
          if (rise) begin
            if (period_ok) begin
              good <= good_inc;
              if (good_inc == GOOD_TARGET) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              good <= '0;
            end
          end else if (timeout) begin
            state <= IDLE;
            good  <= '0;
          end
        end

        LOCKED: begin
          if (rise && !period_ok) begin
            state  <= MEAS;
            good   <= '0;
            locked <= 1'b0;
          end else if (timeout) begin
            state  <= IDLE;
            good   <= '0;
            locked <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          good   <= '0;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/freq_div_monitor.sv
// Monitor for the three divided clocks (50 %, 10 %, 1 % of CLK_in).
// One checker per channel; err_clr is shared by all of them and
// all_locked tells system logic every tick is trustworthy as a clock enable.
module freq_div_monitor
  import freq_div_mon_pkg::*;
#(
  parameter int P50    = P50_DEF,
  parameter int P10    = P10_DEF,
  parameter int P1     = P1_DEF,
  parameter int LOCK_N = LOCK_N_DEF
) (
  input  logic               CLK_in,
  input  logic               RST,
  freq_div_monitor_if.slave  bus
);

  logic [2:0] tick_w;
  logic [2:0] locked_w;
  logic [2:0] err_w;

  freq_chan_check #(
    .P      (P50),
    .LOCK_N (LOCK_N)
  ) u_chan_50 (
    .CLK_in  (CLK_in),
    .RST     (RST),
    .clk_div (bus.CLK_50_i),
    .err_clr (bus.err_clr),
    .tick    (tick_w[0]),
    .locked  (locked_w[0]),
    .err     (err_w[0])
  );

  freq_chan_check #(
    .P      (P10),
    .LOCK_N (LOCK_N)
  ) u_chan_10 (
    .CLK_in  (CLK_in),
    .RST     (RST),
    .clk_div (bus.CLK_10_i),
    .err_clr (bus.err_clr),
    .tick    (tick_w[1]),
    .locked  (locked_w[1]),
    .err     (err_w[1])
  );

  freq_chan_check #(
    .P      (P1),
    .LOCK_N (LOCK_N)
  ) u_chan_1 (
    .CLK_in  (CLK_in),
    .RST     (RST),
    .clk_div (bus.CLK_1_i),
    .err_clr (bus.err_clr),
    .tick    (tick_w[2]),
    .locked  (locked_w[2]),
    .err     (err_w[2])
  );

  assign bus.tick       = tick_w;
  assign bus.locked     = locked_w;
  assign bus.err        = err_w;
  assign bus.all_locked = &locked_w;

endmodule

// File: tb/tb_freq_div_monitor.sv
// Directed bench for freq_div_monitor: nominal lock, a wrong-period channel,
// a stalled channel with timeout and relock, a lengthened period with the
// err_clr/fault collision, and an asynchronous reset in mid-measurement.
module tb_freq_div_monitor;

  logic CLK_in = 1'b0;
  logic RST    = 1'b0;

  freq_div_monitor_if bus ();

  freq_div_monitor #(
    .P50    (2),
    .P10    (10),
    .P1     (100),
    .LOCK_N (4)
  ) dut (
    .CLK_in (CLK_in),
    .RST    (RST),
    .bus    (bus)
  );

  always #5 CLK_in = ~CLK_in;

  int         n_cmp  = 0;
  int         n_fail = 0;
  int         cyc    = 0;
  int         per [3];
  int         ph  [3];
  bit         run [3];
  logic [2:0] last_v   = 3'b000;
  logic [2:0] rise_exp = 3'b000;
  logic       clr      = 1'b0;

  // One comparison: counted, and reported with tag/observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s (cycle %0d): observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  // Drive one cycle of divider waveforms plus err_clr, then step past the edge.
  task automatic applyStimulus();
    logic [2:0] v;
    for (int c = 0; c < 3; c++) begin
      if (run[c]) begin
        v[c]  = (ph[c] < per[c] / 2);
        ph[c] = (ph[c] + 1) % per[c];
      end else begin
        v[c]  = 1'b0;
        ph[c] = 0;
      end
    end
    rise_exp     = v & ~last_v;
    last_v       = v;
    bus.CLK_50_i = v[0];
    bus.CLK_10_i = v[1];
    bus.CLK_1_i  = v[2];
    bus.err_clr  = clr;
    @(posedge CLK_in);
    #1;
    cyc++;
  endtask

  // Advance to cycle n, checking every tick against the driven edges.
  task automatic run_to(input int n);
    while (cyc < n) begin
      applyStimulus();
      checkOutput("tick", bus.tick, rise_exp);
    end
  endtask

  // Assert reset mid-cycle, check the asynchronous clear, then restart the waveforms.
  task automatic do_reset();
    #2;
    RST = 1'b1;
    #1;
    checkOutput("rst_tick", bus.tick, 3'b000);
    checkOutput("rst_locked", bus.locked, 3'b000);
    checkOutput("rst_err", bus.err, 3'b000);
    checkOutput("rst_all_locked", {2'b00, bus.all_locked}, 3'b000);
    bus.CLK_50_i = 1'b0;
    bus.CLK_10_i = 1'b0;
    bus.CLK_1_i  = 1'b0;
    clr          = 1'b0;
    bus.err_clr  = 1'b0;
    per[0] = 2;
    per[1] = 10;
    per[2] = 100;
    for (int c = 0; c < 3; c++) begin
      run[c] = 1'b1;
      ph[c]  = 0;
    end
    last_v = 3'b000;
    repeat (2) @(posedge CLK_in);
    @(negedge CLK_in);
    RST = 1'b0;
    cyc = 0;
  endtask

  initial begin
    bus.CLK_50_i = 1'b0;
    bus.CLK_10_i = 1'b0;
    bus.CLK_1_i  = 1'b0;
    bus.err_clr  = 1'b0;

    // Nominal 2/10/100 waveforms: locks after the 5th edge of each channel.
    $display("[TB] nominal lock");
    do_reset();
    run_to(8);
    checkOutput("nom_locked_c8", bus.locked, 3'b000);
    run_to(9);
    checkOutput("nom_locked_c9", bus.locked, 3'b001);
    run_to(40);
    checkOutput("nom_locked_c40", bus.locked, 3'b001);
    run_to(41);
    checkOutput("nom_locked_c41", bus.locked, 3'b011);
    run_to(400);
    checkOutput("nom_locked_c400", bus.locked, 3'b011);
    checkOutput("nom_all_c400", {2'b00, bus.all_locked}, 3'b000);
    run_to(401);
    checkOutput("nom_locked_c401", bus.locked, 3'b111);
    checkOutput("nom_all_c401", {2'b00, bus.all_locked}, 3'b001);
    checkOutput("nom_err_c401", bus.err, 3'b000);

    // CLK_1 at period 20: never locks, never times out, never errors.
    $display("[TB] wrong period on CLK_1");
    do_reset();
    per[2] = 20;
    run_to(41);
    checkOutput("p20_locked_c41", bus.locked, 3'b011);
    run_to(200);
    checkOutput("p20_locked_c200", bus.locked, 3'b011);
    checkOutput("p20_err_c200", bus.err, 3'b000);
    checkOutput("p20_all_c200", {2'b00, bus.all_locked}, 3'b000);

    // CLK_10 held low after lock: last rise at 51, timeout 20 cycles later.
    $display("[TB] stalled CLK_10");
    do_reset();
    run_to(55);
    checkOutput("stall_locked_c55", bus.locked, 3'b011);
    run[1] = 1'b0;
    run_to(70);
    checkOutput("stall_locked_c70", bus.locked, 3'b011);
    checkOutput("stall_err_c70", bus.err, 3'b000);
    run_to(71);
    checkOutput("stall_locked_c71", bus.locked, 3'b001);
    checkOutput("stall_err_c71", bus.err, 3'b010);
    run_to(79);
    run[1] = 1'b1;
    run_to(119);
    checkOutput("relock_locked_c119", bus.locked, 3'b001);
    run_to(120);
    checkOutput("relock_locked_c120", bus.locked, 3'b011);
    checkOutput("relock_err_c120", bus.err, 3'b010);

    // Reset while CLK_1 sits at good = 2 and CLK_50 has just ticked.
    $display("[TB] reset mid-measurement");
    run_to(251);
    checkOutput("pre_rst_locked", bus.locked, 3'b011);
    checkOutput("pre_rst_err", bus.err, 3'b010);
    do_reset();
    run_to(400);
    checkOutput("post_rst_locked_c400", bus.locked, 3'b011);
    run_to(401);
    checkOutput("post_rst_locked_c401", bus.locked, 3'b111);
    checkOutput("post_rst_err_c401", bus.err, 3'b000);

    // One 3-cycle CLK_50 period while locked, relock, then err_clr vs fault.
    $display("[TB] lengthened CLK_50 period");
    do_reset();
    run_to(11);
    checkOutput("long_locked_c11", bus.locked, 3'b001);
    per[0] = 3;
    run_to(13);
    per[0] = 2;
    checkOutput("long_locked_c13", bus.locked, 3'b001);
    checkOutput("long_err_c13", bus.err, 3'b000);
    run_to(14);
    checkOutput("long_locked_c14", bus.locked, 3'b000);
    checkOutput("long_err_c14", bus.err, 3'b001);
    run_to(21);
    checkOutput("long_locked_c21", bus.locked, 3'b000);
    run_to(22);
    checkOutput("long_locked_c22", bus.locked, 3'b001);
    clr = 1'b1;
    run_to(24);
    clr = 1'b0;
    checkOutput("clr_err_c24", bus.err, 3'b000);
    run_to(28);
    per[0] = 3;
    run_to(30);
    per[0] = 2;
    clr = 1'b1;
    run_to(31);
    clr = 1'b0;
    checkOutput("clr_vs_fault_err_c31", bus.err, 3'b001);
    checkOutput("clr_vs_fault_locked_c31", bus.locked, 3'b000);
    run_to(32);
    checkOutput("sticky_err_c32", bus.err, 3'b001);
    clr = 1'b1;
    run_to(33);
    clr = 1'b0;
    checkOutput("clr_err_c33", bus.err, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
